// File: rtl/int_to_float.sv
// int_to_float: multi-cycle signed 32-bit integer to IEEE-754 single converter.
// The magnitude is normalised by repeated coarse (8-bit) and fine (1-bit) left
// shifts. It is then rounded to nearest, ties to even. The start/done handshake
// is qualified by clk_en, and every register holds while clk_en is low.
module int_to_float #(
    parameter int EXP_BIAS     = 127,
    parameter int COARSE_SHIFT = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    output logic        done,
    output logic [31:0] result
);

    // The exponent starts as if the leading one sat at bit 31.
    localparam logic [7:0] EXP_PRESET = 8'(EXP_BIAS + 31);
    localparam logic [7:0] COARSE_EXP = 8'(COARSE_SHIFT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] mag_q, mag_d;
    logic [7:0]  exp_q, exp_d;
    logic        sign_q, sign_d;
    logic [31:0] result_q, result_d;
    logic        done_q, done_d;

    // Operand decode. The two's-complement negate of INT_MIN is 32'h80000000,
    // which is the correct unsigned magnitude, so no special case is needed.
    logic [31:0] abs_in;
    logic        in_zero;
    assign abs_in  = dataa[31] ? (~dataa + 32'd1) : dataa;
    assign in_zero = (dataa == 32'd0);

    // Normalisation decisions for the current magnitude.
    logic norm_done;
    logic coarse_ok;
    assign norm_done = mag_q[31];
    assign coarse_ok = (mag_q[31 -: COARSE_SHIFT] == '0);

    // Round-to-nearest-even on the normalised magnitude. Bit 31 is the hidden
    // one, bits 30:8 are the fraction, bit 7 is guard, and bits 6:0 are sticky.
    logic [22:0] frac_raw;
    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [23:0] frac_sum;
    logic [7:0]  exp_rnd;
    assign frac_raw = mag_q[30:8];
    assign guard    = mag_q[7];
    assign sticky   = |mag_q[6:0];
    assign round_up = guard & (sticky | frac_raw[0]);
    assign frac_sum = {1'b0, frac_raw} + {23'd0, round_up};
    // A carry out of the fraction means the mantissa became 1.0 * 2^(e+1).
    // The low 23 bits of frac_sum are already zero in that case.
    assign exp_rnd  = exp_q + {7'd0, frac_sum[23]};

    // State register; frozen whenever clk_en is low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else if (clk_en) begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start && !in_zero) begin
                    state_d = NORM;
                end
            end
            NORM: begin
                if (norm_done) begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath and output next values. done defaults low so that it is a
    // single enabled-cycle pulse.
    always_comb begin
        mag_d    = mag_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sign_d = dataa[31];
                    mag_d  = abs_in;
                    exp_d  = EXP_PRESET;
                    if (in_zero) begin
                        // Zero has no leading one to find, so it finishes at once as +0.
                        result_d = 32'h0000_0000;
                        done_d   = 1'b1;
                    end
                end
            end
            NORM: begin
                if (!norm_done) begin
                    if (coarse_ok) begin
                        mag_d = mag_q << COARSE_SHIFT;
                        exp_d = exp_q - COARSE_EXP;
                    end else begin
                        mag_d = mag_q << 1;
                        exp_d = exp_q - 8'd1;
                    end
                end
            end
            ROUND: begin
                result_d = {sign_q, exp_rnd, frac_sum[22:0]};
                done_d   = 1'b1;
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; held while clk_en is low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mag_q    <= 32'd0;
            exp_q    <= 8'd0;
            sign_q   <= 1'b0;
            result_q <= 32'd0;
            done_q   <= 1'b0;
        end else if (clk_en) begin
            mag_q    <= mag_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_int_to_float.sv
// tb_int_to_float: scoreboard bench for int_to_float.
// The driver pushes the expected result and completion cycle for each accepted
// start. The monitor pops and compares them on every new done pulse.
module tb_int_to_float;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clk_en;
    logic        start;
    logic [31:0] dataa;
    logic        done;
    logic [31:0] result;

    int_to_float dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clk_en  (clk_en),
        .start   (start),
        .dataa   (dataa),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] din;
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic en_last = 1'b0;

    function automatic void check32(string name, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endfunction

    // Reference conversion from plain integer arithmetic. It finds the msb,
    // then rounds the dropped bits to nearest, ties to even.
    function automatic int msb_pos(longint m);
        int p = 0;
        while ((m >> (p + 1)) != 0) p++;
        return p;
    endfunction

    function automatic logic [31:0] ref_conv(logic [31:0] d);
        longint v, m, q, rem, half;
        int     p, sh, e;
        logic   s;
        logic [31:0] r;
        v = longint'($signed(d));
        s = (v < 0);
        m = s ? -v : v;
        if (m == 0) return 32'h0;
        p = msb_pos(m);
        e = 127 + p;
        if (p <= 23) begin
            q = m << (23 - p);
        end else begin
            sh   = p - 23;
            q    = m >> sh;
            rem  = m - (q << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == (longint'(1) << 24)) begin
                q = q >> 1;
                e = e + 1;
            end
        end
        r = {s, 8'(e), 23'(q)};
        return r;
    endfunction

    // Cycles from the accepting edge to done. The count of leading zeros is
    // consumed eight at a time where possible, then one at a time.
    function automatic int ref_lat(logic [31:0] d);
        longint v, m;
        int lz;
        v = longint'($signed(d));
        m = (v < 0) ? -v : v;
        if (m == 0) return 0;
        lz = 31 - msb_pos(m);
        return (lz / 8) + (lz % 8) + 2;
    endfunction

    // Edge counter and a record of whether the last edge was enabled.
    always @(posedge clk) begin
        cyc++;
        en_last = clk_en;
    end

    // Monitor: each enabled-edge done is a new pulse and must match the head of the queue.
    always @(negedge clk) begin
        if (reset_n && done && en_last) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: result %h at cycle %0d, none expected", result, cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check32($sformatf("result(%h)", e.din), result, e.res);
                checks++;
                if (cyc != e.cyc) begin
                    errors++;
                    $display("FAIL latency(%h): done at cycle %0d expected %0d", e.din, cyc, e.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one start. The accepting edge is cyc+1, and stall adds known disabled cycles.
    task automatic launch(input logic [31:0] d, input logic [31:0] expv, input int stall);
        exp_t e;
        e.din = d;
        e.res = expv;
        e.cyc = cyc + 1 + ref_lat(d) + stall;
        sbq.push_back(e);
        start = 1'b1;
        dataa = d;
        tick();
        start = 1'b0;
        dataa = $urandom;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 60) begin
            tick();
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout: done not seen within %0d cycles", n);
        end
    endtask

    task automatic convert(input logic [31:0] d, input logic [31:0] expv);
        launch(d, expv, 0);
        wait_done();
    endtask

    logic [31:0] dir_in  [9] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF,
                                 32'h8000_0000, 32'h7FFF_FFFF, 32'h4000_0000,
                                 32'h0100_0001, 32'h0100_0003, 32'h0100_0005};
    logic [31:0] dir_out [9] = '{32'h0000_0000, 32'h3F80_0000, 32'hBF80_0000,
                                 32'hCF00_0000, 32'h4F00_0000, 32'h4E80_0000,
                                 32'h4B80_0000, 32'h4B80_0002, 32'h4B80_0002};

    initial begin
        logic [31:0] d;
        reset_n = 1'b0;
        clk_en  = 1'b1;
        start   = 1'b0;
        dataa   = 32'd0;
        #3;
        check32("reset_done", {31'd0, done}, 32'd0);
        check32("reset_result", result, 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Directed values; the expected words are the known IEEE encodings.
        foreach (dir_in[i]) begin
            convert(dir_in[i], dir_out[i]);
            tick();
        end

        // A start pulsed during NORM must not disturb the conversion in flight.
        launch(32'h0000_0001, 32'h3F80_0000, 0);
        tick();
        tick();
        start = 1'b1;
        dataa = 32'h0000_0005;
        tick();
        start = 1'b0;
        wait_done();
        tick();

        // Five disabled cycles mid-NORM push done out by exactly five cycles.
        launch(32'h0000_0001, 32'h3F80_0000, 5);
        tick();
        tick();
        clk_en = 1'b0;
        repeat (5) tick();
        clk_en = 1'b1;
        wait_done();

        // Back-to-back: start is asserted again in the cycle done is high.
        convert(32'hFFFF_FF00, ref_conv(32'hFFFF_FF00));
        convert(32'h0000_0000, 32'h0000_0000);
        convert(32'h0000_0000, 32'h0000_0000);
        convert(32'h00AB_CDEF, ref_conv(32'h00AB_CDEF));
        tick();

        // A reset during NORM clears the outputs at once and leaves no pulse afterwards.
        launch(32'h0000_0001, 32'h3F80_0000, 0);
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        check32("abort_done", {31'd0, done}, 32'd0);
        check32("abort_result", result, 32'd0);
        sbq.delete();
        tick();
        tick();
        reset_n = 1'b1;
        repeat (15) tick();

        // Random operands over a spread of magnitudes, with random gaps between starts.
        for (int k = 0; k < 3000; k++) begin
            d = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) d = -d;
            if ($urandom_range(0, 15) == 0) d = 32'h8000_0000;
            convert(d, ref_conv(d));
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (20) tick();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL missing_done: %0d expected results never appeared", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
